sd_match_logger: RTL
====================

Name: sd_match_logger

Overview:
- Downstream consumer of the sequence-detector FSM's one-bit detector_out.
- Counts detections, timestamps each one against a free-running cycle counter, and buffers the timestamps in a small FIFO.
- Software or an LA/Wishbone shim pops the FIFO through a valid/ready handshake.
- Sits in user_project_wrapper beside the detector, on the same clock and reset.

Parameters:
- CNT_W, 16, width of the saturating match counter.
- TS_W, 16, width of the cycle timestamp counter and of each FIFO entry.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.

Ports:
- clock  in  1  system clock (wb_clk_i); all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  high: timestamp runs and matches are recorded.
- clear  in  1  synchronous clear of counter, timestamp, FIFO and overflow.
- detector_in  in  1  detector_out from the sequence detector.
- match_count  out  CNT_W  total matches recorded since reset/clear.
- evt_valid  out  1  FIFO non-empty; evt_ts holds the oldest entry.
- evt_ready  in  1  consumer accepts evt_ts when evt_valid is also high.
- evt_ts  out  TS_W  timestamp of the oldest buffered match.
- fifo_level  out  $clog2(DEPTH)+1  number of entries held, 0..DEPTH.
- overflow  out  1  sticky: a match was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, release sync to clock): all outputs 0. Stored ts, counters and pointers are 0.
- Timestamp ts:
  - Increments by 1 each cycle while enable=1 and clear=0.
  - Wraps from 2^TS_W-1 to 0.
  - Holds while enable=0.
- Match definition: every cycle in which detector_in=1 and enable=1 is one match.
  - Level-per-cycle, not edge detection, so overlapping detections on consecutive cycles each count.
  - detector_in is already registered by the FSM, so no extra synchronizer is used.
- On a match at edge t:
  - match_count increments, saturating at 2^CNT_W-1 (no wrap).
  - The value of ts before its own increment at edge t is pushed.
  - The new entry is visible on evt_ts/evt_valid after edge t if the FIFO was empty. There is no same-cycle bypass.
- Pop: when evt_valid=1 and evt_ready=1 at an edge, the head is discarded and evt_ts shows the next entry after that edge.
  - evt_ready with evt_valid=0 is ignored.
  - evt_ts is don't-care when evt_valid=0; the bench checks it only when valid.
- FIFO state machine, tracked as fifo_level with states EMPTY (0), PARTIAL, FULL (DEPTH):
  - Push only: level +1.
  - Pop only: level -1.
  - Push and pop together: level unchanged, and both take effect, including at FULL, where the push is accepted because a slot frees the same edge.
  - Push at FULL without pop: entry dropped, overflow set to 1. match_count still increments.
  - Push and pop at EMPTY: the pop is ignored (evt_valid=0) and the push is stored, giving level 1.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by the level counter or by an extra pointer bit.
- clear=1:
  - Next edge sets match_count=0, ts=0, level=0 and overflow=0.
  - Overrides any push or pop in the same cycle.
  - Acts regardless of enable.
- enable=0: matches are ignored and ts is frozen. Pops still work and the contents are retained.
- Reset mid-operation: immediate return to the reset values. No partially written entry survives.
- Latency summary:
  - Match to match_count: 1 cycle.
  - Match to evt_valid (from empty): 1 cycle.
  - Pop to next head: 1 cycle.

Decomposition:
- Package sd_pkg:
  - SD_CNT_W=16, SD_TS_W=16, SD_EVT_DEPTH=8.
  - Typedef sd_ts_t (logic [SD_TS_W-1:0]).
  - Typedef sd_cnt_t.
- Sub-module sd_evt_fifo:
  - Synchronous FIFO, TS_W wide, DEPTH deep.
  - push/pop/level/full/empty interface.
  - Async active-high reset.
- sd_match_logger holds the timestamp, the counter, the overflow flag, and the push/clear gating around it.

Test Plan:
- Reset with enable=1, detector_in=0 for 10 cycles -> match_count=0, evt_valid=0, fifo_level=0, overflow=0. Internal ts reads 10 via the first subsequent match's timestamp.
- After reset, enable=1, single detector_in pulse at cycle 5 (ts=5) -> next cycle match_count=1, evt_valid=1, evt_ts=5. Pop it -> evt_valid=0, level=0.
- detector_in high for 3 consecutive cycles at ts=20,21,22, evt_ready=0 -> match_count=3, level=3. Pops in order return 20, 21, 22.
- 9 matches with DEPTH=8 and no pops -> level=8, overflow=1, match_count=9. Drain returns the first 8 timestamps. A subsequent clear -> overflow=0, match_count=0.
- FIFO full with push and pop on the same edge -> level stays 8, overflow stays 0, and the newest entry is appended after the previous 7.
- Force match_count to 0xFFFF via 65535 matches (or a shortened CNT_W=4 build: 15 matches) -> one more match leaves it saturated at max. Assert async reset mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared widths, types and FIFO occupancy states for the sequence-detector match logger.
package sd_pkg;

    localparam int SD_CNT_W     = 16;
    localparam int SD_TS_W      = 16;
    localparam int SD_EVT_DEPTH = 8;

    typedef logic [SD_TS_W-1:0]  sd_ts_t;
    typedef logic [SD_CNT_W-1:0] sd_cnt_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } sd_fifo_state_e;

endpackage

// File: rtl/sd_evt_fifo.sv
// Timestamp FIFO with an occupancy FSM; the head entry is held in its own register
// so the read data comes straight from a flop.
module sd_evt_fifo
    import sd_pkg::*;
#(
    parameter int W     = SD_TS_W,
    parameter int DEPTH = SD_EVT_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]   mem_q [DEPTH];
    logic [W-1:0]   mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [W-1:0]   head_q, head_d;
    sd_fifo_state_e state_q, state_d;
    logic           push_ok_s, pop_ok_s;

    // Storage, pointers, level, head and occupancy state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            state_q  <= FIFO_EMPTY;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            state_q  <= state_d;
        end
    end

    // Next-state: a push at FULL is only taken when a pop frees a slot on the same edge.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        state_d   = state_q;
        pop_ok_s  = pop && (state_q != FIFO_EMPTY);
        push_ok_s = push && ((state_q != FIFO_FULL) || pop_ok_s);

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        head_d = mem_d[rd_ptr_d];

        if (level_d == LW'(0)) begin
            state_d = FIFO_EMPTY;
        end else if (level_d == LW'(DEPTH)) begin
            state_d = FIFO_FULL;
        end else begin
            state_d = FIFO_PARTIAL;
        end
    end

    assign dout  = head_q;
    assign level = level_q;
    assign full  = (state_q == FIFO_FULL);
    assign empty = (state_q == FIFO_EMPTY);

endmodule

// File: rtl/sd_match_logger.sv
// Counts detector matches, timestamps each against a free-running cycle counter
// and queues the timestamps for a valid/ready consumer.
module sd_match_logger
    import sd_pkg::*;
#(
    parameter int CNT_W = SD_CNT_W,
    parameter int TS_W  = SD_TS_W,
    parameter int DEPTH = SD_EVT_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     detector_in,
    output logic [CNT_W-1:0]         match_count,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
    logic             match_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LW-1:0]    fifo_level_s;

    assign match_s = detector_in && enable;

    // Timestamp, match counter and sticky overflow registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Clear wins over enable; the counter saturates instead of wrapping.
    always_comb begin
        ts_d       = ts_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (clear) begin
            ts_d       = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (enable) begin
                ts_d = ts_q + TS_W'(1);
            end else begin
                ts_d = ts_q;
            end
            if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
            if (match_s && fifo_full_s && !evt_ready) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    sd_evt_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (match_s),
        .pop   (evt_ready),
        .din   (ts_q),
        .dout  (evt_ts),
        .level (fifo_level_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign match_count = cnt_q;
    assign overflow    = overflow_q;
    assign fifo_level  = fifo_level_s;
    assign evt_valid   = !fifo_empty_s;

endmodule
